vc_skid_queue: RTL and testbench
================================

VC_SKID_QUEUE -- requirements
Module: vc_skid_queue

Interface
REQ-001 Parameter: p_nbits, default 32, payload width in bits; legal range 1..256.
REQ-002 Port: clk  input  1  clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous active-high reset.
REQ-004 Port: enq_val  input  1  upstream message valid.
REQ-005 Port: enq_rdy  output  1  queue can accept a message this cycle.
REQ-006 Port: enq_msg  input  p_nbits  upstream payload.
REQ-007 Port: deq_val  output  1  head message valid.
REQ-008 Port: deq_rdy  input  1  downstream accepts head this cycle.
REQ-009 Port: deq_msg  output  p_nbits  head payload.
REQ-010 Port: count  output  2  number of occupied entries, 0..2.

Function
REQ-011 Block SHALL be a 2-entry in-order val/rdy queue: head register H and skid register S.
REQ-012 Enqueue fire SHALL be enq_val && enq_rdy; dequeue fire SHALL be deq_val && deq_rdy.
REQ-013 States SHALL be EMPTY (count 0), ONE (count 1, H valid), TWO (count 2, H and S valid).
REQ-014 enq_rdy SHALL equal (state != TWO) && !reset, decoded from state only, with no combinational path from deq_rdy.
REQ-015 deq_val SHALL equal (state != EMPTY); deq_msg SHALL equal H, with no combinational path from enq_* to deq_*.
REQ-016 Latency: a message enqueued into EMPTY at edge N SHALL appear on deq_val/deq_msg in the cycle after edge N; there is no bypass.
REQ-017 EMPTY: enq fire -> ONE, H <= enq_msg; otherwise stay EMPTY.
REQ-018 ONE: enq only -> TWO, S <= enq_msg; deq only -> EMPTY; enq and deq together -> stay ONE, H <= enq_msg; neither -> stay ONE.
REQ-019 TWO: deq fire -> ONE, H <= S; no deq -> stay TWO; enqueue is impossible because enq_rdy is 0.
REQ-020 While deq_val && !deq_rdy, deq_msg SHALL hold stable across cycles.
REQ-021 Messages SHALL be delivered exactly once, in enqueue order, with no loss or duplication.
REQ-022 enq_msg SHALL be ignored when enq fire is 0; H/S SHALL not change except as given in REQ-017..019.
REQ-023 count SHALL be registered state, encoded 0/1/2; value 3 SHALL never occur.
REQ-024 When reset is deasserted, an X on enq_val or deq_rdy SHALL trigger a simulation-only assertion failure.

Reset
REQ-025 On reset assertion, state SHALL go to EMPTY immediately (asynchronously), independent of clk.
REQ-026 During and after reset: count=0, deq_val=0, deq_msg=0 (H cleared), S=0; enq_rdy=0 while reset is high.
REQ-027 Reset asserted mid-operation SHALL discard all held messages; first edge after deassertion behaves as EMPTY.
REQ-028 Reset deassertion SHALL occur synchronously to clk, as guaranteed by the system; enq_rdy=1 in the first cycle after.

Verification
REQ-029 Reset then idle: after reset release, count=0, deq_val=0, enq_rdy=1, deq_msg=0 for 5 cycles.
REQ-030 Single pass: enq 0xA5A5A5A5 with deq_rdy=1 -> next cycle deq_val=1, deq_msg=0xA5A5A5A5; following cycle count=0.
REQ-031 Backpressure fill: deq_rdy=0, enq 0x11, then 0x22 -> count=2, enq_rdy=0, deq_msg=0x11 held; a third enq_val=1 is not accepted.
REQ-032 Drain order: from REQ-031, raise deq_rdy for 2 cycles -> deq_msg 0x11 then 0x22; count 2->1->0; enq_rdy=1 after first deq.
REQ-033 Streaming: enq_val=1 and deq_rdy=1 every cycle with messages 1..100 -> output 1..100 in order, one per cycle after 1-cycle latency, count stays 1.
REQ-034 Async reset mid-flight: count=2, pulse reset between clock edges -> count=0, deq_val=0 before the next edge; the next enq 0x33 is the first message out.

Source files
------------

// File: rtl/vc_skid_queue.sv
// vc_skid_queue: two-entry in-order val/rdy queue built from a head register
// and a skid register. Outputs are decoded from registered state only, so
// there is no combinational path from enq_* to deq_* or from deq_rdy to enq_rdy.
module vc_skid_queue #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg,
  output logic [1:0]         count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [p_nbits-1:0] head;
  logic [p_nbits-1:0] skid;
  logic               enq_fire;
  logic               deq_fire;

  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  // State register; reset drops the queue to EMPTY immediately, discarding contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode from the enqueue/dequeue handshakes
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (enq_fire) state_next = ONE;
      end
      ONE: begin
        if (enq_fire && !deq_fire)      state_next = TWO;
        else if (!enq_fire && deq_fire) state_next = EMPTY;
      end
      TWO: begin
        if (deq_fire) state_next = ONE;
      end
      default: state_next = EMPTY;
    endcase
  end

  // Outputs depend on state (and reset for enq_rdy) only
  always_comb begin
    enq_rdy = (state != TWO) && !reset;
    deq_val = (state != EMPTY);
    count   = state;
    deq_msg = head;
  end

  // Payload registers: head is always the oldest message, skid holds the second
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      skid <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (enq_fire) head <= enq_msg;
        end
        ONE: begin
          if (enq_fire && deq_fire) head <= enq_msg;
          else if (enq_fire)        skid <= enq_msg;
        end
        TWO: begin
          if (deq_fire) head <= skid;
        end
        default: ;
      endcase
    end
  end

  // Handshake inputs must be known whenever the queue is out of reset
  a_no_x_handshake : assert property (@(posedge clk) disable iff (reset)
    !$isunknown({enq_val, deq_rdy}));

  // The two-bit occupancy encoding never reaches 3
  a_count_legal : assert property (@(posedge clk) disable iff (reset)
    state != 2'd3);

endmodule

// File: tb/tb_vc_skid_queue.sv
// Testbench for vc_skid_queue: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of a 2-deep FIFO.
module tb_vc_skid_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enq_val = 1'b0;
  logic        enq_rdy;
  logic [31:0] enq_msg = '0;
  logic        deq_val;
  logic        deq_rdy = 1'b0;
  logic [31:0] deq_msg;
  logic [1:0]  count;

  int errors = 0;
  int checks = 0;

  // Reference model: contents in order, plus the value last presented at the head
  logic [31:0] model_q[$];
  logic [31:0] last_head = '0;

  vc_skid_queue #(.p_nbits(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq_val),
    .enq_rdy (enq_rdy),
    .enq_msg (enq_msg),
    .deq_val (deq_val),
    .deq_rdy (deq_rdy),
    .deq_msg (deq_msg),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle starting at a negedge: drive inputs, compare outputs with the
  // model, let the rising edge happen, advance the model, return at next negedge.
  task automatic step(input logic ev, input logic [31:0] em, input logic dr);
    logic e_fire;
    logic d_fire;
    enq_val = ev;
    enq_msg = em;
    deq_rdy = dr;
    #1;
    check("count",   {30'd0, count},   model_q.size());
    check("enq_rdy", {31'd0, enq_rdy}, (model_q.size() < 2) ? 32'd1 : 32'd0);
    check("deq_val", {31'd0, deq_val}, (model_q.size() > 0) ? 32'd1 : 32'd0);
    check("deq_msg", deq_msg,          last_head);
    e_fire = ev && (model_q.size() < 2);
    d_fire = dr && (model_q.size() > 0);
    @(posedge clk);
    if (d_fire) void'(model_q.pop_front());
    if (e_fire) model_q.push_back(em);
    if (model_q.size() > 0) last_head = model_q[0];
    @(negedge clk);
  endtask

  initial begin
    // Hold reset into the first negedge and check reset outputs
    @(negedge clk);
    check("rst_count",   {30'd0, count},   32'd0);
    check("rst_deq_val", {31'd0, deq_val}, 32'd0);
    check("rst_enq_rdy", {31'd0, enq_rdy}, 32'd0);
    check("rst_deq_msg", deq_msg,          32'd0);
    reset = 1'b0;

    // Idle after reset release
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0);

    // Single pass with one-cycle latency
    step(1'b1, 32'hA5A5A5A5, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);

    // Backpressure fill, third enqueue refused
    step(1'b1, 32'h11, 1'b0);
    step(1'b1, 32'h22, 1'b0);
    step(1'b1, 32'h33, 1'b0);
    step(1'b0, 32'h44, 1'b0);

    // Drain in order
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b0);

    // Streaming 1..100, then drain
    for (int i = 1; i <= 100; i++) step(1'b1, i, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b0);

    // Fill to two, then pulse reset between clock edges
    step(1'b1, 32'h55, 1'b0);
    step(1'b1, 32'h66, 1'b0);
    check("pre_rst_count", {30'd0, count}, 32'd2);
    enq_val = 1'b0;
    deq_rdy = 1'b0;
    reset   = 1'b1;
    #1;
    check("async_count",   {30'd0, count},   32'd0);
    check("async_deq_val", {31'd0, deq_val}, 32'd0);
    check("async_enq_rdy", {31'd0, enq_rdy}, 32'd0);
    check("async_deq_msg", deq_msg,          32'd0);
    #2;
    reset = 1'b0;
    model_q.delete();
    last_head = '0;
    @(negedge clk);
    step(1'b1, 32'h33, 1'b0);
    check("after_rst_first", deq_msg, 32'h33);
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
